// File: rtl/edge_bin_packer.sv
// edge_bin_packer: thresholds the Sobel edge-magnitude stream to 1 bit per
// pixel and packs 8 bits per byte, row by row, with a per-frame done pulse
// and a per-frame edge-pixel count.
// Optional build macro: EDGE_BIN_HYST_EN adds row-local hysteresis
// (a pixel >= T/2 stays an edge when the previous pixel in the row was one).
module edge_bin_packer #(
    parameter int OUT_WIDTH  = 318,
    parameter int OUT_HEIGHT = 238
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_in_valid,
    input  logic [7:0]  pixel_in,
    input  logic [7:0]  thresh_in,
    output logic        pack_out_valid,
    output logic [7:0]  pack_out,
    output logic        frame_done,
    output logic [31:0] edge_count
);

    localparam int CW = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;
    localparam int RW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic [31:0]   run_cnt;
    logic [7:0]    thresh_q;
`ifdef EDGE_BIN_HYST_EN
    logic          prev_bit;
`endif

    logic       first_px;
    logic [7:0] thr;
    logic       px_bit;
    logic       row_end;
    logic       frame_end;
    logic       emit;
    logic [7:0] cur_byte;

    // Binarize the current pixel and build the byte it completes (if any).
    always_comb begin
        first_px  = (col == '0) && (row == '0);
        // The first pixel of a frame uses the live threshold; it is latched for the rest.
        thr       = first_px ? thresh_in : thresh_q;
        px_bit    = (pixel_in >= thr);
`ifdef EDGE_BIN_HYST_EN
        // Previous bit is ignored at col 0 so hysteresis never crosses a row boundary.
        px_bit    = px_bit | ((pixel_in >= (thr >> 1)) && prev_bit && (col != '0));
`endif
        row_end   = (col == COL_LAST);
        frame_end = row_end && (row == ROW_LAST);
        emit      = row_end || (bit_idx == 3'd7);
        cur_byte  = shift_q | ({7'd0, px_bit} << bit_idx);
    end

    // Accept pixels: advance counters, shift in bits, emit bytes and frame totals.
    always_ff @(posedge clk) begin
        if (rst) begin
            col            <= '0;
            row            <= '0;
            bit_idx        <= '0;
            shift_q        <= '0;
            run_cnt        <= '0;
            thresh_q       <= '0;
            pack_out_valid <= 1'b0;
            pack_out       <= '0;
            frame_done     <= 1'b0;
            edge_count     <= '0;
`ifdef EDGE_BIN_HYST_EN
            prev_bit       <= 1'b0;
`endif
        end else begin
            pack_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            if (pixel_in_valid) begin
                if (first_px)
                    thresh_q <= thresh_in;
`ifdef EDGE_BIN_HYST_EN
                prev_bit <= px_bit;
`endif
                // Row end flushes a partial byte; cleared shift keeps unused bits 0.
                if (emit) begin
                    pack_out       <= cur_byte;
                    pack_out_valid <= 1'b1;
                    shift_q        <= '0;
                    bit_idx        <= '0;
                end else begin
                    shift_q        <= cur_byte;
                    bit_idx        <= bit_idx + 3'd1;
                end
                if (row_end) begin
                    col <= '0;
                    row <= frame_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (frame_end) begin
                    frame_done <= 1'b1;
                    edge_count <= run_cnt + {31'd0, px_bit};
                    run_cnt    <= '0;
                end else begin
                    run_cnt    <= run_cnt + {31'd0, px_bit};
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_bin_packer.sv
// tb_edge_bin_packer: directed checks on a 10x2 instance plus a full default
// 318x238 frame with random valid gaps against a byte/count scoreboard.
module tb_edge_bin_packer;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // small 10x2 instance
    logic        s_valid, s_pov, s_fd;
    logic [7:0]  s_pix, s_thr, s_po;
    logic [31:0] s_ec;

    // default-size instance
    logic        l_valid, l_pov, l_fd;
    logic [7:0]  l_pix, l_thr, l_po;
    logic [31:0] l_ec;

    edge_bin_packer #(.OUT_WIDTH(10), .OUT_HEIGHT(2)) dut_s (
        .clk(clk), .rst(rst), .pixel_in_valid(s_valid), .pixel_in(s_pix),
        .thresh_in(s_thr), .pack_out_valid(s_pov), .pack_out(s_po),
        .frame_done(s_fd), .edge_count(s_ec)
    );

    edge_bin_packer dut_l (
        .clk(clk), .rst(rst), .pixel_in_valid(l_valid), .pixel_in(l_pix),
        .thresh_in(l_thr), .pack_out_valid(l_pov), .pack_out(l_po),
        .frame_done(l_fd), .edge_count(l_ec)
    );

`ifdef EDGE_BIN_HYST_EN
    localparam logic [7:0] EA0 = 8'h0E;
    localparam logic [7:0] EA1 = 8'h03;
    localparam int         EA_CNT = 15;
`else
    localparam logic [7:0] EA0 = 8'h0A;
    localparam logic [7:0] EA1 = 8'h01;
    localparam int         EA_CNT = 13;
`endif
    localparam int LT = 128;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] p);
        s_valid = 1'b1;
        s_pix   = p;
        step();
        s_valid = 1'b0;
    endtask

    // One 10-pixel row; byte checks after the 8th and 10th pixel.
    task automatic push_row(input string tg, input logic [7:0] px [10],
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic fd, input logic [31:0] cnt,
                            input logic chg, input logic [7:0] nthr, input int gap_at);
        for (int i = 0; i < 10; i++) begin
            push(px[i]);
            if (i == 0 && chg) s_thr = nthr;
            if (i == gap_at) begin
                step(); step();
                chk({tg, "_gap_v"}, {31'd0, s_pov}, 32'd0);
            end
            if (i == 7) begin
                chk({tg, "_v0"}, {31'd0, s_pov}, 32'd1);
                chk({tg, "_b0"}, {24'd0, s_po}, {24'd0, b0});
            end
            if (i == 8) begin
                chk({tg, "_v_off"}, {31'd0, s_pov}, 32'd0);
                chk({tg, "_hold"}, {24'd0, s_po}, {24'd0, b0});
            end
            if (i == 9) begin
                chk({tg, "_v1"}, {31'd0, s_pov}, 32'd1);
                chk({tg, "_b1"}, {24'd0, s_po}, {24'd0, b1});
                chk({tg, "_fd"}, {31'd0, s_fd}, {31'd0, fd});
                if (fd) chk({tg, "_cnt"}, s_ec, cnt);
            end
        end
    endtask

    // scoreboard for the default-size instance
    logic [7:0] exp_q [$];
    int strobes = 0;
    int fd_cnt  = 0;
    int bad     = 0;

    always @(negedge clk) begin
        if (l_pov) begin
            strobes++;
            if (exp_q.size() == 0) bad++;
            else if (l_po !== exp_q.pop_front()) bad++;
        end
        if (l_fd) begin
            fd_cnt++;
            if (!l_pov) bad++;
        end
    end

    logic [7:0] row_a  [10];
    logic [7:0] row_ff [10];
`ifdef EDGE_BIN_HYST_EN
    logic [7:0] row_h  [10];
    logic [7:0] row_60 [10];
`endif

    initial begin
        int   mcount;
        logic mbit, mprev;
        logic [7:0] mbyte;
        int   midx;

        row_a  = '{8'd0, 8'd100, 8'd99, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd120, 8'd50};
        row_ff = '{default: 8'd255};
`ifdef EDGE_BIN_HYST_EN
        row_h  = '{8'd120, 8'd60, 8'd60, 8'd40, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        row_60 = '{default: 8'd60};
`endif
        s_valid = 1'b0; s_pix = '0; s_thr = 8'd100;
        l_valid = 1'b0; l_pix = '0; l_thr = 8'(LT);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_pov", {31'd0, s_pov}, 32'd0);
        chk("rst_po",  {24'd0, s_po},  32'd0);
        chk("rst_fd",  {31'd0, s_fd},  32'd0);
        chk("rst_ec",  s_ec,           32'd0);

        // frame A: T=100
        push_row("a_r0", row_a,  EA0,   EA1,   1'b0, 32'd0, 1'b0, 8'd0, -1);
        push_row("a_r1", row_ff, 8'hFF, 8'h03, 1'b1, EA_CNT, 1'b0, 8'd0, -1);
        step();
        chk("a_idle_fd",  {31'd0, s_fd},  32'd0);
        chk("a_idle_pov", {31'd0, s_pov}, 32'd0);
        chk("a_ec_hold",  s_ec, EA_CNT);
        chk("a_po_hold",  {24'd0, s_po}, 32'h03);

        // frame B: threshold drops to 0 after the first pixel, no effect this frame
        push_row("b_r0", row_a,  EA0,   EA1,   1'b0, 32'd0, 1'b1, 8'd0, 4);
        push_row("b_r1", row_ff, 8'hFF, 8'h03, 1'b1, EA_CNT, 1'b0, 8'd0, -1);
        // frame C back-to-back: latches 0, all ones
        push_row("c_r0", row_a,  8'hFF, 8'h03, 1'b0, 32'd0, 1'b0, 8'd0, -1);
        push_row("c_r1", row_a,  8'hFF, 8'h03, 1'b1, 32'd20, 1'b0, 8'd0, -1);

        // reset mid-row: stale ones must not leak into the next byte
        s_thr = 8'd100;
        for (int i = 0; i < 5; i++) push(8'd255);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_pov", {31'd0, s_pov}, 32'd0);
        chk("mid_rst_ec",  s_ec, 32'd0);
        push_row("r_r0", row_a,  EA0,   EA1,   1'b0, 32'd0, 1'b0, 8'd0, -1);
        push_row("r_r1", row_ff, 8'hFF, 8'h03, 1'b1, EA_CNT, 1'b0, 8'd0, -1);

`ifdef EDGE_BIN_HYST_EN
        push_row("h_r0", row_h,  8'h07, 8'h00, 1'b0, 32'd0, 1'b0, 8'd0, -1);
        push_row("h_r1", row_60, 8'h00, 8'h00, 1'b1, 32'd3, 1'b0, 8'd0, -1);
`endif

        // full default frame with random gaps
        mcount = 0; mprev = 1'b0; mbyte = '0; midx = 0;
        for (int r = 0; r < 238; r++) begin
            for (int c = 0; c < 318; c++) begin
                while ($urandom_range(99) < 8) begin
                    l_valid = 1'b0;
                    step();
                end
                l_valid = 1'b1;
                l_pix   = 8'($urandom_range(255));
                mbit    = (int'(l_pix) >= LT);
`ifdef EDGE_BIN_HYST_EN
                mbit    = mbit | ((int'(l_pix) >= LT / 2) && mprev && (c != 0));
`endif
                mprev   = mbit;
                mbyte[midx] = mbit;
                midx++;
                mcount += int'(mbit);
                if (midx == 8 || c == 317) begin
                    exp_q.push_back(mbyte);
                    mbyte = '0;
                    midx  = 0;
                end
                step();
            end
        end
        l_valid = 1'b0;
        step(); step(); step();
        chk("big_strobes", strobes, 32'd9520);
        chk("big_fd",      fd_cnt,  32'd1);
        chk("big_ec",      l_ec,    mcount);
        chk("big_bytes",   bad,     32'd0);
        chk("big_q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
